// File: rtl/vx_writeback_arb.sv
// Writeback arbiter for one issue slice.
// Collects result beats from NUM_REQS execute units and emits one registered
// writeback beat per cycle. Round-robin between packets; a multi-beat packet
// (sop..eop) holds the grant until its eop beat, so packets never interleave.
// The writeback side has no ready, so stalls only ever reach the EX units.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | between packets; round-robin scan starting after 'last'
// LOCKED | mid-packet; only lock_idx may be granted, output may bubble
module vx_writeback_arb #(
  parameter int NUM_REQS      = 4,
  parameter int PERF_CTR_BITS = 44,
  parameter int UUID_WIDTH    = 44,
  parameter int ISSUE_WIS_W   = 2,
  parameter int NUM_THREADS   = 4,
  parameter int PC_BITS       = 32,
  parameter int NR_BITS       = 6,
  parameter int XLEN          = 32
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_REQS-1:0]                          result_valid,
  input  logic [NUM_REQS-1:0][UUID_WIDTH-1:0]          result_uuid,
  input  logic [NUM_REQS-1:0][ISSUE_WIS_W-1:0]         result_wis,
  input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]         result_tmask,
  input  logic [NUM_REQS-1:0][PC_BITS-1:0]             result_PC,
  input  logic [NUM_REQS-1:0][NR_BITS-1:0]             result_rd,
  input  logic [NUM_REQS-1:0][NUM_THREADS*XLEN-1:0]    result_data,
  input  logic [NUM_REQS-1:0]                          result_sop,
  input  logic [NUM_REQS-1:0]                          result_eop,
  output logic [NUM_REQS-1:0]                          result_ready,
  output logic                                         writeback_valid,
  output logic [UUID_WIDTH-1:0]                        writeback_uuid,
  output logic [ISSUE_WIS_W-1:0]                       writeback_wis,
  output logic [NUM_THREADS-1:0]                       writeback_tmask,
  output logic [PC_BITS-1:0]                           writeback_PC,
  output logic [NR_BITS-1:0]                           writeback_rd,
  output logic [NUM_THREADS*XLEN-1:0]                  writeback_data,
  output logic                                         writeback_sop,
  output logic                                         writeback_eop,
  output logic [PERF_CTR_BITS-1:0]                     perf_stalls
);

  localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] lock_idx;
  logic [IDX_W-1:0] last;

  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             stall;

  // Grant selection: locked unit only while mid-packet, else round-robin after 'last'.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    if (!reset) begin
      if (state == ST_LOCKED) begin
        grant_valid = result_valid[lock_idx];
        grant_idx   = lock_idx;
      end else begin
        for (int k = 1; k <= NUM_REQS; k++) begin
          cand_idx = IDX_W'((int'(last) + k) % NUM_REQS);
          if (!grant_valid && result_valid[cand_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = cand_idx;
          end
        end
      end
    end
  end

  // One-hot ready back to the EX units, plus the stall indication for the counter.
  always_comb begin
    result_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      result_ready[i] = grant_valid && (grant_idx == IDX_W'(i));
    end
    stall = |(result_valid & ~result_ready);
  end

  // Packet lock tracking and round-robin pointer; 'last' moves once per packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      lock_idx <= '0;
      last     <= IDX_W'(NUM_REQS - 1);
    end else if (grant_valid) begin
      if (result_eop[grant_idx]) begin
        state <= ST_IDLE;
        last  <= grant_idx;
      end else begin
        state    <= ST_LOCKED;
        lock_idx <= grant_idx;
      end
    end
  end

  // Registered writeback beat; payload holds across cycles with no grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      writeback_valid <= 1'b0;
      writeback_uuid  <= '0;
      writeback_wis   <= '0;
      writeback_tmask <= '0;
      writeback_PC    <= '0;
      writeback_rd    <= '0;
      writeback_data  <= '0;
      writeback_sop   <= 1'b0;
      writeback_eop   <= 1'b0;
    end else begin
      writeback_valid <= grant_valid;
      if (grant_valid) begin
        writeback_uuid  <= result_uuid[grant_idx];
        writeback_wis   <= result_wis[grant_idx];
        writeback_tmask <= result_tmask[grant_idx];
        writeback_PC    <= result_PC[grant_idx];
        writeback_rd    <= result_rd[grant_idx];
        writeback_data  <= result_data[grant_idx];
        writeback_sop   <= result_sop[grant_idx];
        writeback_eop   <= result_eop[grant_idx];
      end
    end
  end

  // Stall counter: cycles where some valid requester was not granted; wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls <= '0;
    end else if (stall) begin
      perf_stalls <= perf_stalls + {{(PERF_CTR_BITS-1){1'b0}}, 1'b1};
    end
  end

`ifndef SYNTHESIS
  // A new packet must not start from the unit that still owns an open packet.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_LOCKED) begin
      assert (!(result_valid[lock_idx] && result_sop[lock_idx]))
        else $error("vx_writeback_arb: sop from locked unit %0d mid-packet", lock_idx);
    end
  end
`endif

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Bench for vx_writeback_arb: directed tables/sequences plus a randomized run
// against a packet-level reference model.
module tb_vx_writeback_arb;

  localparam int N   = 4;
  localparam int PB  = 44;
  localparam int UW  = 44;
  localparam int WW  = 2;
  localparam int NT  = 4;
  localparam int PCB = 32;
  localparam int NRB = 6;
  localparam int XL  = 32;
  localparam int DW  = NT * XL;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [N-1:0]          result_valid;
  logic [N-1:0][UW-1:0]  result_uuid;
  logic [N-1:0][WW-1:0]  result_wis;
  logic [N-1:0][NT-1:0]  result_tmask;
  logic [N-1:0][PCB-1:0] result_PC;
  logic [N-1:0][NRB-1:0] result_rd;
  logic [N-1:0][DW-1:0]  result_data;
  logic [N-1:0]          result_sop;
  logic [N-1:0]          result_eop;
  logic [N-1:0]          result_ready;
  logic                  writeback_valid;
  logic [UW-1:0]         writeback_uuid;
  logic [WW-1:0]         writeback_wis;
  logic [NT-1:0]         writeback_tmask;
  logic [PCB-1:0]        writeback_PC;
  logic [NRB-1:0]        writeback_rd;
  logic [DW-1:0]         writeback_data;
  logic                  writeback_sop;
  logic                  writeback_eop;
  logic [PB-1:0]         perf_stalls;

  always #5 clk = ~clk;

  vx_writeback_arb #(
    .NUM_REQS(N), .PERF_CTR_BITS(PB), .UUID_WIDTH(UW), .ISSUE_WIS_W(WW),
    .NUM_THREADS(NT), .PC_BITS(PCB), .NR_BITS(NRB), .XLEN(XL)
  ) dut (
    .clk(clk), .reset(reset),
    .result_valid(result_valid), .result_uuid(result_uuid), .result_wis(result_wis),
    .result_tmask(result_tmask), .result_PC(result_PC), .result_rd(result_rd),
    .result_data(result_data), .result_sop(result_sop), .result_eop(result_eop),
    .result_ready(result_ready),
    .writeback_valid(writeback_valid), .writeback_uuid(writeback_uuid),
    .writeback_wis(writeback_wis), .writeback_tmask(writeback_tmask),
    .writeback_PC(writeback_PC), .writeback_rd(writeback_rd),
    .writeback_data(writeback_data), .writeback_sop(writeback_sop),
    .writeback_eop(writeback_eop), .perf_stalls(perf_stalls)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  int            m_last;
  bit            m_locked;
  int            m_lock;
  logic          exp_wv;
  logic [UW-1:0] exp_uuid;
  logic [WW-1:0] exp_wis;
  logic [NT-1:0] exp_tmask;
  logic [PCB-1:0] exp_pc;
  logic [NRB-1:0] exp_rd;
  logic [DW-1:0] exp_data;
  logic          exp_sop, exp_eop;
  logic [PB-1:0] exp_perf;

  bit            g_gv;
  int            g_gi;
  logic [N-1:0]  smp_ready;
  logic          smp_wv;
  logic [UW-1:0] smp_uuid;
  logic [PB-1:0] smp_perf;

  function automatic void model_reset();
    m_last = N - 1; m_locked = 0; m_lock = 0;
    exp_wv = 0; exp_uuid = '0; exp_wis = '0; exp_tmask = '0; exp_pc = '0;
    exp_rd = '0; exp_data = '0; exp_sop = 0; exp_eop = 0; exp_perf = '0;
  endfunction

  // Who should get the grant this cycle, from the packet-level rules.
  task automatic model_grant();
    int order[$];
    g_gv = 0; g_gi = 0;
    if (reset) return;
    if (m_locked) begin
      g_gv = result_valid[m_lock];
      g_gi = m_lock;
      return;
    end
    for (int k = 1; k <= N; k++) order.push_back((m_last + k) % N);
    foreach (order[j]) begin
      if (result_valid[order[j]]) begin
        g_gv = 1; g_gi = order[j];
        return;
      end
    end
  endtask

  task automatic set_unit(input int i, input bit v, input bit sop, input bit eop,
                          input logic [UW-1:0] uuid);
    result_valid[i] = v;
    result_sop[i]   = sop;
    result_eop[i]   = eop;
    result_uuid[i]  = uuid;
    result_wis[i]   = 2'(i);
    result_tmask[i] = 4'(i + 1);
    result_PC[i]    = uuid[31:0] + 32'h1000;
    result_rd[i]    = uuid[5:0];
    result_data[i]  = {4{uuid[31:0] ^ 32'h5a5a_0000}};
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_unit(i, 0, 0, 0, '0);
  endtask

  // One clock: inputs already driven; sample at the falling edge, then advance model.
  task automatic cycle();
    logic [N-1:0] er;
    model_grant();
    er = g_gv ? N'(1 << g_gi) : '0;
    #4;
    smp_ready = result_ready;
    smp_wv    = writeback_valid;
    smp_uuid  = writeback_uuid;
    smp_perf  = perf_stalls;
    chk("ready", result_ready, er);
    chk("wb_valid", writeback_valid, exp_wv);
    chk("wb_uuid", writeback_uuid, exp_uuid);
    chk("wb_wis", writeback_wis, exp_wis);
    chk("wb_tmask", writeback_tmask, exp_tmask);
    chk("wb_pc", writeback_PC, exp_pc);
    chk("wb_rd", writeback_rd, exp_rd);
    chk("wb_data", writeback_data, exp_data);
    chk("wb_sop", writeback_sop, exp_sop);
    chk("wb_eop", writeback_eop, exp_eop);
    chk("perf_stalls", perf_stalls, exp_perf);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (|(result_valid & ~er)) exp_perf = exp_perf + 1'b1;
      exp_wv = g_gv;
      if (g_gv) begin
        exp_uuid  = result_uuid[g_gi];
        exp_wis   = result_wis[g_gi];
        exp_tmask = result_tmask[g_gi];
        exp_pc    = result_PC[g_gi];
        exp_rd    = result_rd[g_gi];
        exp_data  = result_data[g_gi];
        exp_sop   = result_sop[g_gi];
        exp_eop   = result_eop[g_gi];
        if (result_eop[g_gi]) begin
          m_locked = 0; m_last = g_gi;
        end else begin
          m_locked = 1; m_lock = g_gi;
        end
      end
    end
    #1;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
    logic         exp_wv;
  } vec_t;

  vec_t t2_tab[8];
  vec_t t5_tab[10];

  // Randomized packet generator state
  int r_len[N];
  int r_beat[N];
  int r_id[N];

  task automatic new_packet(input int i);
    r_beat[i] = 0;
    r_len[i]  = $urandom_range(1, 4);
    r_id[i]++;
  endtask

  initial begin
    logic [N-1:0] t3_exp[6];
    logic [N-1:0] t4_exp[7];
    logic         t4_wv[7];

    for (int r = 0; r < 8; r++) begin
      t2_tab[r].valid     = 4'hF;
      t2_tab[r].exp_ready = 4'(1 << (r % 4));
      t2_tab[r].exp_wv    = (r != 0);
    end
    for (int r = 0; r < 10; r++) begin
      t5_tab[r].valid     = 4'b1001;
      t5_tab[r].exp_ready = (r % 2 == 0) ? 4'b0001 : 4'b1000;
      t5_tab[r].exp_wv    = (r != 0);
    end
    t3_exp = '{4'h2, 4'h2, 4'h2, 4'h4, 4'h8, 4'h1};
    t4_exp = '{4'h4, 4'h0, 4'h0, 4'h4, 4'h4, 4'h8, 4'h1};
    t4_wv  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    clear_all();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // T1: reset held with every unit requesting
    for (int i = 0; i < N; i++) set_unit(i, 1, 1, 1, 44'(i + 1));
    repeat (3) begin
      cycle();
      chk("t1_ready", smp_ready, 4'h0);
      chk("t1_wv", smp_wv, 1'b0);
      chk("t1_perf", smp_perf, 0);
    end
    reset = 1'b0;

    // T2: single beats from all four units rotate 0,1,2,3
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        set_unit(i, t2_tab[r].valid[i], 1, 1, 44'(16 * i + r + 100));
      cycle();
      chk("t2_ready", smp_ready, t2_tab[r].exp_ready);
      chk("t2_wv", smp_wv, t2_tab[r].exp_wv);
      if (r > 0) chk("t2_uuid", smp_uuid, 44'(16 * ((r - 1) % 4) + (r - 1) + 100));
    end

    // T3: 3-beat packet from unit 1 is not interleaved
    clear_all();
    set_unit(0, 1, 1, 1, 44'd200);
    cycle();
    chk("t3_pre_ready", smp_ready, 4'h1);
    for (int s = 0; s < 6; s++) begin
      if (s < 3) set_unit(1, 1, s == 0, s == 2, 44'(300 + s));
      else       set_unit(1, 0, 0, 0, '0);
      set_unit(0, 1, 1, 1, 44'(400 + s));
      set_unit(2, 1, 1, 1, 44'(420 + s));
      set_unit(3, 1, 1, 1, 44'(440 + s));
      cycle();
      chk("t3_ready", smp_ready, t3_exp[s]);
      if (s >= 1 && s <= 3) chk("t3_uuid", smp_uuid, 44'(300 + s - 1));
    end

    // T4: locked unit 2 drops valid for two cycles -> output bubbles
    clear_all();
    for (int s = 0; s < 7; s++) begin
      set_unit(0, 1, 1, 1, 44'(500 + s));
      set_unit(3, 1, 1, 1, 44'(520 + s));
      case (s)
        0:       set_unit(2, 1, 1, 0, 44'd540);
        3:       set_unit(2, 1, 0, 0, 44'd541);
        4:       set_unit(2, 1, 0, 1, 44'd542);
        default: set_unit(2, 0, 0, 0, '0);
      endcase
      cycle();
      chk("t4_ready", smp_ready, t4_exp[s]);
      chk("t4_wv", smp_wv, t4_wv[s]);
    end

    // T5: units 0 and 3 contend for 10 cycles after a fresh reset
    clear_all();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++)
        set_unit(i, t5_tab[r].valid[i], 1, 1, 44'(600 + 16 * i + r));
      cycle();
      chk("t5_ready", smp_ready, t5_tab[r].exp_ready);
      chk("t5_wv", smp_wv, t5_tab[r].exp_wv);
    end
    clear_all();
    cycle();
    chk("t5_perf", smp_perf, 10);

    // T6: reset during the second beat of a 4-beat packet discards the lock
    set_unit(1, 1, 1, 0, 44'd700);
    cycle();
    chk("t6_first", smp_ready, 4'h2);
    set_unit(1, 1, 0, 0, 44'd701);
    set_unit(0, 1, 1, 1, 44'd710);
    reset = 1'b1;
    cycle();
    chk("t6_in_reset", smp_ready, 4'h0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_unit(i, 1, 1, 1, 44'(720 + i));
    cycle();
    chk("t6_post_ready", smp_ready, 4'h1);
    chk("t6_post_wv", smp_wv, 1'b0);
    cycle();
    chk("t6_next_ready", smp_ready, 4'h2);

    // Randomized run: variable-length packets, random valid gaps, rare resets
    for (int i = 0; i < N; i++) new_packet(i);
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++)
        set_unit(i, $urandom_range(0, 3) != 0, r_beat[i] == 0, r_beat[i] == r_len[i] - 1,
                 44'(i * 1000000 + r_id[i] * 8 + r_beat[i]));
      cycle();
      if (reset) begin
        for (int i = 0; i < N; i++) new_packet(i);
      end else if (g_gv) begin
        r_beat[g_gi]++;
        if (r_beat[g_gi] == r_len[g_gi]) new_packet(g_gi);
      end
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
